// File: rtl/regfile_dec_if.sv
// Register-file port bundle: one write port, two read ports, decoded strobe
// and committed-write counter. The decode stage is the master.
interface regfile_dec_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic [ADDR_W-1:0]      raddr1;
    logic [ADDR_W-1:0]      raddr2;
    logic [DATA_W-1:0]      rdata1;
    logic [DATA_W-1:0]      rdata2;
    logic [2**ADDR_W-1:0]   wsel;
    logic [7:0]             wcount;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2, wsel, wcount
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2, wsel, wcount
    );
endinterface

// File: rtl/regfile_dec.sv
// Parametrised register file: one-hot write decoder, one synchronous write
// port, two combinational read ports, optional hardwired r0 and bypass.

// One storage register; loads d on a clock edge when en is high.
module regfile_dec_cell #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    // Async reset to RST_VAL, otherwise load on enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= RST_VAL;
        else if (en) q <= d;
    end
endmodule

module regfile_dec #(
    parameter int                 ADDR_W   = 5,
    parameter int                 DATA_W   = 32,
    parameter int                 ZERO_REG = 1,
    parameter int                 BYPASS   = 1,
    parameter logic [DATA_W-1:0]  RST_VAL  = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_dec_if.slave bus
);
    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0]             wsel;
    logic [NREG-1:0]             commit;
    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]           rdata1, rdata2;
    logic [7:0]                  wcount;

    genvar i;
    generate
        for (i = 0; i < NREG; i++) begin : g_reg
            // N-to-2^N decode, gated by we; reported unmasked on the port.
            assign wsel[i] = bus.we & (bus.waddr == ADDR_W'(i));

            if (ZERO_REG != 0 && i == 0) begin : g_zero
                // r0 has no storage; its strobe never commits.
                assign commit[i] = 1'b0;
                assign regs[i]   = '0;
            end else begin : g_cell
                assign commit[i] = wsel[i];
                regfile_dec_cell #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_cell (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (commit[i]),
                    .d     (bus.wdata),
                    .q     (regs[i])
                );
            end
        end
    endgenerate

    // Read port 1: storage, then bypass, then the r0 zero rule (highest priority).
    always_comb begin
        rdata1 = regs[bus.raddr1];
        if (BYPASS != 0 && bus.we && bus.waddr == bus.raddr1) rdata1 = bus.wdata;
        if (ZERO_REG != 0 && bus.raddr1 == '0)                rdata1 = '0;
    end

    // Read port 2: same priority as port 1, fully independent.
    always_comb begin
        rdata2 = regs[bus.raddr2];
        if (BYPASS != 0 && bus.we && bus.waddr == bus.raddr2) rdata2 = bus.wdata;
        if (ZERO_REG != 0 && bus.raddr2 == '0)                rdata2 = '0;
    end

    // Count writes that actually land in storage; saturate at 255.
    // Reset holds all cells, so writes during reset are never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         wcount <= '0;
        else if (|commit && wcount != 8'hFF) wcount <= wcount + 8'd1;
    end

    assign bus.wsel   = wsel;
    assign bus.rdata1 = rdata1;
    assign bus.rdata2 = rdata2;
    assign bus.wcount = wcount;
endmodule

// File: tb/tb_regfile_dec.sv
// Directed bench for regfile_dec: default config, a no-bypass config and a
// small 8x8 config with ordinary r0, all sharing one clock and reset.
module tb_regfile_dec;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    regfile_dec_if #(.ADDR_W(5), .DATA_W(32)) b0 ();
    regfile_dec_if #(.ADDR_W(5), .DATA_W(32)) b1 ();
    regfile_dec_if #(.ADDR_W(3), .DATA_W(8))  b2 ();

    regfile_dec #(.ADDR_W(5), .DATA_W(32), .ZERO_REG(1), .BYPASS(1), .RST_VAL(32'h0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    regfile_dec #(.ADDR_W(5), .DATA_W(32), .ZERO_REG(1), .BYPASS(0), .RST_VAL(32'h0))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    regfile_dec #(.ADDR_W(3), .DATA_W(8), .ZERO_REG(0), .BYPASS(0), .RST_VAL(8'h0))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (b0.wcount !== 8'd0) begin n_bad++; $display("FAIL reset_wcount0: got %0d want 0", b0.wcount); end
        n_cmp++; if (b1.wcount !== 8'd0) begin n_bad++; $display("FAIL reset_wcount1: got %0d want 0", b1.wcount); end
        n_cmp++; if (b2.wcount !== 8'd0) begin n_bad++; $display("FAIL reset_wcount2: got %0d want 0", b2.wcount); end
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            b0.raddr1 = 5'(a);
            b0.raddr2 = 5'(31 - a);
            #1;
            n_cmp++; if (b0.rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rd1[%0d]: got %h want 0", a, b0.rdata1); end
            n_cmp++; if (b0.rdata2 !== 32'h0) begin n_bad++; $display("FAIL reset_rd2[%0d]: got %h want 0", 31 - a, b0.rdata2); end
        end
        tick();
    endtask

    task automatic test_write_r5();
        b0.we = 1'b1; b0.waddr = 5'd5; b0.wdata = 32'hDEADBEEF; b0.raddr1 = 5'd5; b0.raddr2 = 5'd6;
        #2;
        n_cmp++; if (b0.wsel !== 32'h0000_0020) begin n_bad++; $display("FAIL r5_wsel: got %h want 00000020", b0.wsel); end
        n_cmp++; if (b0.rdata1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL r5_bypass: got %h want deadbeef", b0.rdata1); end
        tick();
        b0.we = 1'b0;
        #2;
        n_cmp++; if (b0.wsel !== 32'h0) begin n_bad++; $display("FAIL idle_wsel: got %h want 0", b0.wsel); end
        n_cmp++; if (b0.rdata1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL r5_read: got %h want deadbeef", b0.rdata1); end
        n_cmp++; if (b0.rdata2 !== 32'h0) begin n_bad++; $display("FAIL r6_untouched: got %h want 0", b0.rdata2); end
        n_cmp++; if (b0.wcount !== 8'd1) begin n_bad++; $display("FAIL r5_wcount: got %0d want 1", b0.wcount); end
        tick();
    endtask

    task automatic test_zero_reg();
        b0.we = 1'b1; b0.waddr = 5'd0; b0.wdata = 32'h12345678; b0.raddr1 = 5'd0; b0.raddr2 = 5'd0;
        #2;
        n_cmp++; if (b0.wsel !== 32'h0000_0001) begin n_bad++; $display("FAIL r0_wsel: got %h want 00000001", b0.wsel); end
        n_cmp++; if (b0.rdata1 !== 32'h0) begin n_bad++; $display("FAIL r0_no_bypass: got %h want 0", b0.rdata1); end
        tick();
        b0.we = 1'b0;
        #2;
        n_cmp++; if (b0.rdata2 !== 32'h0) begin n_bad++; $display("FAIL r0_read: got %h want 0", b0.rdata2); end
        n_cmp++; if (b0.wcount !== 8'd1) begin n_bad++; $display("FAIL r0_wcount: got %0d want 1", b0.wcount); end
        tick();
    endtask

    task automatic test_bypass();
        // Seed r7 with an old value on both 32-bit instances.
        b0.we = 1'b1; b0.waddr = 5'd7; b0.wdata = 32'h11111111;
        b1.we = 1'b1; b1.waddr = 5'd7; b1.wdata = 32'h11111111;
        tick();
        b0.raddr1 = 5'd7; b0.raddr2 = 5'd7; b0.wdata = 32'hA5A5A5A5;
        b1.raddr1 = 5'd7; b1.raddr2 = 5'd7; b1.wdata = 32'hA5A5A5A5;
        #2;
        n_cmp++; if (b0.rdata1 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL byp_on_rd1: got %h want a5a5a5a5", b0.rdata1); end
        n_cmp++; if (b0.rdata2 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL byp_on_rd2: got %h want a5a5a5a5", b0.rdata2); end
        n_cmp++; if (b1.rdata1 !== 32'h11111111) begin n_bad++; $display("FAIL byp_off_rd1: got %h want 11111111", b1.rdata1); end
        n_cmp++; if (b1.rdata2 !== 32'h11111111) begin n_bad++; $display("FAIL byp_off_rd2: got %h want 11111111", b1.rdata2); end
        tick();
        b0.we = 1'b0; b1.we = 1'b0;
        #2;
        n_cmp++; if (b1.rdata1 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL byp_off_after: got %h want a5a5a5a5", b1.rdata1); end
        n_cmp++; if (b0.wcount !== 8'd3) begin n_bad++; $display("FAIL byp_wcount0: got %0d want 3", b0.wcount); end
        n_cmp++; if (b1.wcount !== 8'd2) begin n_bad++; $display("FAIL byp_wcount1: got %0d want 2", b1.wcount); end
        tick();
    endtask

    task automatic test_back_to_back();
        b0.we = 1'b1; b0.waddr = 5'd9; b0.wdata = 32'h1;
        tick();
        b0.wdata = 32'h2;
        tick();
        b0.we = 1'b0; b0.raddr1 = 5'd9;
        #2;
        n_cmp++; if (b0.rdata1 !== 32'h2) begin n_bad++; $display("FAIL b2b_last_wins: got %h want 2", b0.rdata1); end
        n_cmp++; if (b0.wcount !== 8'd5) begin n_bad++; $display("FAIL b2b_wcount: got %0d want 5", b0.wcount); end
        tick();
    endtask

    task automatic test_saturation_and_reset();
        b0.we = 1'b1;
        for (int i = 0; i < 300; i++) begin
            b0.waddr = 5'(1 + i % 31);
            b0.wdata = 32'(i);
            tick();
            if (i == 239) begin
                n_cmp++; if (b0.wcount !== 8'd245) begin n_bad++; $display("FAIL sat_pre: got %0d want 245", b0.wcount); end
            end
        end
        n_cmp++; if (b0.wcount !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d want 255", b0.wcount); end
        // Last write to r3 was i=281; keep writing elsewhere while probing r3.
        b0.waddr = 5'd10; b0.wdata = 32'h77; b0.raddr1 = 5'd3; b0.raddr2 = 5'd10;
        #1;
        n_cmp++; if (b0.rdata1 !== 32'd281) begin n_bad++; $display("FAIL sat_r3: got %h want 119", b0.rdata1); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (b0.wcount !== 8'd0) begin n_bad++; $display("FAIL async_wcount: got %0d want 0", b0.wcount); end
        n_cmp++; if (b0.rdata1 !== 32'h0) begin n_bad++; $display("FAIL async_r3: got %h want 0", b0.rdata1); end
        n_cmp++; if (b0.wsel !== 32'h0000_0400) begin n_bad++; $display("FAIL rst_wsel: got %h want 00000400", b0.wsel); end
        tick();
        n_cmp++; if (b0.wcount !== 8'd0) begin n_bad++; $display("FAIL rst_ignore_we: got %0d want 0", b0.wcount); end
        rst_n = 1'b1;
        tick();
        b0.we = 1'b0;
        #2;
        n_cmp++; if (b0.wcount !== 8'd1) begin n_bad++; $display("FAIL first_edge_wcount: got %0d want 1", b0.wcount); end
        n_cmp++; if (b0.rdata2 !== 32'h77) begin n_bad++; $display("FAIL first_edge_r10: got %h want 77", b0.rdata2); end
        tick();
    endtask

    task automatic test_sweep_small();
        logic [7:0] exp;
        b2.we = 1'b1;
        for (int a = 0; a < 8; a++) begin
            b2.waddr = 3'(a);
            b2.wdata = 8'h3C ^ 8'(a * 17);
            #2;
            exp = 8'h01 << a;
            n_cmp++; if (b2.wsel !== exp) begin n_bad++; $display("FAIL sweep_wsel[%0d]: got %h want %h", a, b2.wsel, exp); end
            tick();
        end
        b2.we = 1'b0;
        for (int a = 0; a < 8; a++) begin
            b2.raddr1 = 3'(a);
            b2.raddr2 = 3'(7 - a);
            #1;
            exp = 8'h3C ^ 8'(a * 17);
            n_cmp++; if (b2.rdata1 !== exp) begin n_bad++; $display("FAIL sweep_rd1[%0d]: got %h want %h", a, b2.rdata1, exp); end
            exp = 8'h3C ^ 8'((7 - a) * 17);
            n_cmp++; if (b2.rdata2 !== exp) begin n_bad++; $display("FAIL sweep_rd2[%0d]: got %h want %h", 7 - a, b2.rdata2, exp); end
        end
        n_cmp++; if (b2.wsel !== 8'h00) begin n_bad++; $display("FAIL sweep_idle_wsel: got %h want 00", b2.wsel); end
        n_cmp++; if (b2.wcount !== 8'd8) begin n_bad++; $display("FAIL sweep_wcount: got %0d want 8", b2.wcount); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b1;
        b0.we = 1'b0; b0.waddr = '0; b0.wdata = '0; b0.raddr1 = '0; b0.raddr2 = '0;
        b1.we = 1'b0; b1.waddr = '0; b1.wdata = '0; b1.raddr1 = '0; b1.raddr2 = '0;
        b2.we = 1'b0; b2.waddr = '0; b2.wdata = '0; b2.raddr1 = '0; b2.raddr2 = '0;
        #1;
        test_reset();
        test_write_r5();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_saturation_and_reset();
        test_sweep_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
